mem_access_unit: RTL and testbench

- Load/store initiator for the pipelined CPU's MEM stage.
- Accepts one load or store per handshake from the pipeline and drives the single-port word-addressed data memory: combinational read of mem[address], write on posedge when writeEnable is high.
- Memory is word-only, so the unit does sub-word load extraction, sign/zero extension and read-modify-write for byte/halfword stores.
- Returns the result to writeback over a valid/ready response channel.

---
 rtl/mem_access_pkg.sv | 31 +++
 rtl/lsu_byte_lane.sv | 42 ++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Contents: op field layout, size encodings, FSM states and the alignment check.
package mem_access_pkg;

   localparam int OP_STORE_BIT    = 3;
   localparam int OP_UNSIGNED_BIT = 2;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      MERGE_WR,
      RESP
   } state_e;

   // Size 11 is treated as a fault alongside the misaligned cases.
   function automatic logic is_fault(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = addr_lo[0];
         SIZE_W:  bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for a 32-bit little-endian word.
// Produces the extended load value and the read-modify-write store word.
module lsu_byte_lane
   import mem_access_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   input  logic [31:0] st_data,
   output logic [31:0] ld_value,
   output logic [31:0] st_merged
);

   logic [4:0]  byte_base;
   logic [4:0]  half_base;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_base = {addr_lo, 3'b000};
   assign half_base = {addr_lo[1], 4'b0000};

   always_comb begin
      byte_sel = word_i[byte_base +: 8];
      half_sel = word_i[half_base +: 16];

      case (size)
         SIZE_B:  ld_value = ld_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SIZE_H:  ld_value = ld_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_value = word_i;
      endcase

      // Only the addressed lane is replaced; the rest keeps the current memory word.
      st_merged = word_i;
      case (size)
         SIZE_B:  st_merged[byte_base +: 8]  = st_data[7:0];
         SIZE_H:  st_merged[half_base +: 16] = st_data[15:0];
         default: st_merged = st_data;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving a word-only data memory.
// One transaction in flight; sub-word stores use a read-modify-write cycle.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic [TAG_WIDTH-1:0]  resp_tag,
   output logic                  resp_fault,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   state_e                state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;
   logic                  resp_fault_q, resp_fault_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_wen_q, mem_wen_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;

   logic [31:0] ld_value;
   logic [31:0] st_merged;

   lsu_byte_lane u_lane (
      .word_i      (mem_rdata),
      .addr_lo     (addr_lo_q),
      .size        (op_q[1:0]),
      .ld_unsigned (op_q[OP_UNSIGNED_BIT]),
      .st_data     (wdata_q),
      .ld_value    (ld_value),
      .st_merged   (st_merged)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_tag_d   = resp_tag_q;
      resp_fault_d = resp_fault_q;
      mem_addr_d   = mem_addr_q;
      mem_wen_d    = 1'b0;
      mem_wdata_d  = 32'd0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d       = req_op;
               addr_lo_d  = req_addr[1:0];
               wdata_d    = req_wdata;
               resp_tag_d = req_tag;
               if (is_fault(req_op[1:0], req_addr[1:0])) begin
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
                  resp_rdata_d = 32'd0;
                  state_d      = RESP;
               end else begin
                  mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  // Full-word stores need no read, so the write is lined up for ACCESS.
                  if (req_op[OP_STORE_BIT] && (req_op[1:0] == SIZE_W)) begin
                     mem_wen_d   = 1'b1;
                     mem_wdata_d = req_wdata;
                  end
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!op_q[OP_STORE_BIT]) begin
               resp_rdata_d = ld_value;
               resp_fault_d = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else if (op_q[1:0] == SIZE_W) begin
               resp_rdata_d = 32'd0;
               resp_fault_d = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               mem_wen_d   = 1'b1;
               mem_wdata_d = st_merged;
               state_d     = MERGE_WR;
            end
         end
         MERGE_WR: begin
            resp_rdata_d = 32'd0;
            resp_fault_d = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= 4'd0;
         addr_lo_q    <= 2'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_tag_q   <= '0;
         resp_fault_q <= 1'b0;
         mem_addr_q   <= '0;
         mem_wen_q    <= 1'b0;
         mem_wdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_tag_q   <= resp_tag_d;
         resp_fault_q <= resp_fault_d;
         mem_addr_q   <= mem_addr_d;
         mem_wen_q    <= mem_wen_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Reset must block a pending write even when it lands mid-transaction.
   assign mem_wen    = mem_wen_q & rst_n;
   assign mem_wdata  = mem_wen ? mem_wdata_q : 32'd0;
   assign req_ready  = rst_n & (state_q == IDLE);
   assign mem_addr   = mem_addr_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_tag   = resp_tag_q;
   assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-addressed memory model.
// Vector table for single transactions plus hand-written stall and reset sequences.
module tb_mem_access_unit;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0010;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1010;
   localparam logic [3:0] OP_SWU = 4'b1110;
   localparam logic [3:0] OP_LX  = 4'b0011;
   localparam logic [3:0] OP_SX  = 4'b1011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_tag;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_tag;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem_arr [0:63];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  tag;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          exp_lat;
      int          exp_wen;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs [21];

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(32), .TAG_WIDTH(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_tag   (resp_tag),
      .resp_fault (resp_fault),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = mem_arr[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_wen) mem_arr[mem_addr[7:2]] <= mem_wdata;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] tag,
                               input logic [31:0] exp_rdata, input logic exp_fault,
                               input int exp_lat, input int exp_wen,
                               input logic [31:0] exp_wdata);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.tag = tag;
      v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
      v.exp_wen = exp_wen; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one request from IDLE, waits for the response and checks it and the write port.
   task automatic run_txn(input int idx, input vec_t v);
      int          cyc;
      int          wen_cnt;
      int          wen_cyc;
      logic [31:0] wen_data;
      logic [31:0] wen_addr;
      logic        got;
      req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_tag = v.tag;
      req_valid = 1'b1;
      #1;
      chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0; wen_cnt = 0; wen_cyc = 0; wen_data = 0; wen_addr = 0; got = 1'b0;
      while (!got && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (mem_wen) begin
            wen_cnt++; wen_cyc = cyc; wen_data = mem_wdata; wen_addr = mem_addr;
         end
         if (resp_valid) got = 1'b1;
      end
      chk($sformatf("v%0d latency", idx), cyc, v.exp_lat);
      chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
      chk($sformatf("v%0d fault", idx), {31'd0, resp_fault}, {31'd0, v.exp_fault});
      chk($sformatf("v%0d tag", idx), {27'd0, resp_tag}, {27'd0, v.tag});
      chk($sformatf("v%0d wen_count", idx), wen_cnt, v.exp_wen);
      if (v.exp_wen != 0) begin
         chk($sformatf("v%0d wen_cycle", idx), wen_cyc, v.exp_lat - 1);
         chk($sformatf("v%0d wen_data", idx), wen_data, v.exp_wdata);
         chk($sformatf("v%0d wen_addr", idx), wen_addr, v.addr & 32'hFFFF_FFFC);
      end
      $display("txn %0d op=%b addr=%h wdata=%h tag=%0d -> rdata=%h fault=%b tag=%0d lat=%0d writes=%0d",
               idx, v.op, v.addr, v.wdata, v.tag, resp_rdata, resp_fault, resp_tag, cyc, wen_cnt);
      @(negedge clk);
      chk($sformatf("v%0d resp_valid_drop", idx), {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      int          cyc;
      int          late_valid;
      logic        got;

      vecs[0]  = mk(OP_SW,  32'h10, 32'hDEADBEEF, 5'd1,  32'h0,        1'b0, 2, 1, 32'hDEADBEEF);
      vecs[1]  = mk(OP_LW,  32'h10, 32'h0,        5'd2,  32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
      vecs[2]  = mk(OP_LB,  32'h13, 32'h0,        5'd3,  32'hFFFFFFDE, 1'b0, 2, 0, 32'h0);
      vecs[3]  = mk(OP_LBU, 32'h13, 32'h0,        5'd4,  32'h000000DE, 1'b0, 2, 0, 32'h0);
      vecs[4]  = mk(OP_LH,  32'h12, 32'h0,        5'd5,  32'hFFFFDEAD, 1'b0, 2, 0, 32'h0);
      vecs[5]  = mk(OP_LHU, 32'h10, 32'h0,        5'd6,  32'h0000BEEF, 1'b0, 2, 0, 32'h0);
      vecs[6]  = mk(OP_LB,  32'h10, 32'h0,        5'd7,  32'hFFFFFFEF, 1'b0, 2, 0, 32'h0);
      vecs[7]  = mk(OP_SB,  32'h11, 32'h123456AA, 5'd8,  32'h0,        1'b0, 3, 1, 32'hDEADAAEF);
      vecs[8]  = mk(OP_SH,  32'h12, 32'h00007777, 5'd9,  32'h0,        1'b0, 3, 1, 32'h7777AAEF);
      vecs[9]  = mk(OP_LW,  32'h10, 32'h0,        5'd10, 32'h7777AAEF, 1'b0, 2, 0, 32'h0);
      vecs[10] = mk(OP_LH,  32'h11, 32'h0,        5'd11, 32'h0,        1'b1, 1, 0, 32'h0);
      vecs[11] = mk(OP_SW,  32'h12, 32'hCAFEF00D, 5'd12, 32'h0,        1'b1, 1, 0, 32'h0);
      vecs[12] = mk(OP_LX,  32'h10, 32'h0,        5'd13, 32'h0,        1'b1, 1, 0, 32'h0);
      vecs[13] = mk(OP_LW,  32'h11, 32'h0,        5'd14, 32'h0,        1'b1, 1, 0, 32'h0);
      vecs[14] = mk(OP_SX,  32'h10, 32'h11111111, 5'd0,  32'h0,        1'b1, 1, 0, 32'h0);
      vecs[15] = mk(OP_LW,  32'h10, 32'h0,        5'd15, 32'h7777AAEF, 1'b0, 2, 0, 32'h0);
      vecs[16] = mk(OP_SWU, 32'h80000024, 32'h0000807F, 5'd16, 32'h0, 1'b0, 2, 1, 32'h0000807F);
      vecs[17] = mk(OP_LH,  32'h24, 32'h0,        5'd17, 32'hFFFF807F, 1'b0, 2, 0, 32'h0);
      vecs[18] = mk(OP_LBU, 32'h25, 32'h0,        5'd18, 32'h00000080, 1'b0, 2, 0, 32'h0);
      vecs[19] = mk(OP_LB,  32'h24, 32'h0,        5'd19, 32'h0000007F, 1'b0, 2, 0, 32'h0);
      vecs[20] = mk(OP_LHU, 32'h12, 32'h0,        5'd31, 32'h00007777, 1'b0, 2, 0, 32'h0);

      // Reset held with a store request pending: nothing may be accepted or written.
      rst_n = 1'b0; resp_ready = 1'b1;
      req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h10; req_wdata = 32'h1111; req_tag = 5'd1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("rst%0d req_ready", k), {31'd0, req_ready}, 32'd0);
         chk($sformatf("rst%0d mem_wen", k), {31'd0, mem_wen}, 32'd0);
         chk($sformatf("rst%0d resp_valid", k), {31'd0, resp_valid}, 32'd0);
      end
      rst_n = 1'b1; req_valid = 1'b0;
      #1;
      chk("post_rst req_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst resp_rdata", resp_rdata, 32'd0);
      chk("post_rst resp_tag", {27'd0, resp_tag}, 32'd0);
      chk("post_rst resp_fault", {31'd0, resp_fault}, 32'd0);
      chk("post_rst mem_addr", mem_addr, 32'd0);
      chk("post_rst mem_wdata", mem_wdata, 32'd0);
      $display("txn reset: req_ready=%b resp_valid=%b mem_addr=%h", req_ready, resp_valid, mem_addr);

      for (int i = 0; i < 21; i++) run_txn(i, vecs[i]);

      // Back-pressure: response held for three cycles while another request waits.
      resp_ready = 1'b0;
      req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'h0; req_tag = 5'd7; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (resp_valid) got = 1'b1;
      end
      chk("stall latency", cyc, 2);
      req_op = OP_LW; req_addr = 32'h24; req_tag = 5'd9; req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d resp_valid", k), {31'd0, resp_valid}, 32'd1);
         chk($sformatf("stall%0d rdata", k), resp_rdata, 32'h7777AAEF);
         chk($sformatf("stall%0d tag", k), {27'd0, resp_tag}, 32'd7);
         chk($sformatf("stall%0d req_ready", k), {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      chk("stall release resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("stall release req_ready", {31'd0, req_ready}, 32'd1);
      late_valid = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (resp_valid) late_valid++;
      end
      chk("stall no phantom resp", late_valid, 0);
      $display("txn stall: tag=%0d rdata=%h held 3 cycles", resp_tag, resp_rdata);

      // Reset lands in the write cycle of a byte store: the write must be dropped.
      req_op = OP_SB; req_addr = 32'h10; req_wdata = 32'h00000055; req_tag = 5'd3; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("merge mem_wen before reset", {31'd0, mem_wen}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("merge_rst mem_wen", {31'd0, mem_wen}, 32'd0);
      chk("merge_rst mem_wdata", mem_wdata, 32'd0);
      chk("merge_rst req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("merge_rst idle req_ready", {31'd0, req_ready}, 32'd1);
      chk("merge_rst idle resp_valid", {31'd0, resp_valid}, 32'd0);
      $display("txn merge_reset: mem_wen=%b req_ready=%b", mem_wen, req_ready);
      run_txn(21, mk(OP_LW, 32'h10, 32'h0, 5'd22, 32'h7777AAEF, 1'b0, 2, 0, 32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
